// File: rtl/pipe_control_pkg.sv
// Shared ISA encodings and control-bundle types for the pipelined control path.
package pipe_control_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_ADDIU  = 6'b001001;
   localparam logic [5:0] OP_SLTI   = 6'b001010;
   localparam logic [5:0] OP_SLTIU  = 6'b001011;
   localparam logic [5:0] OP_ANDI   = 6'b001100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_XORI   = 6'b001110;
   localparam logic [5:0] OP_LUI    = 6'b001111;
   localparam logic [5:0] OP_LB     = 6'b100000;
   localparam logic [5:0] OP_LH     = 6'b100001;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_LBU    = 6'b100100;
   localparam logic [5:0] OP_LHU    = 6'b100101;
   localparam logic [5:0] OP_SB     = 6'b101000;
   localparam logic [5:0] OP_SH     = 6'b101001;
   localparam logic [5:0] OP_SW     = 6'b101011;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_SLLV = 6'b000100;
   localparam logic [5:0] FN_SRLV = 6'b000110;
   localparam logic [5:0] FN_SRAV = 6'b000111;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_JALR = 6'b001001;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   // Pseudo-functions handed to the ALU by non-R-type instructions.
   localparam logic [5:0] PF_ADDR   = FN_ADD;
   localparam logic [5:0] PF_BR_EQ  = FN_SUB;
   localparam logic [5:0] PF_BR_CMP = FN_SLT;

   localparam logic [4:0] RI_BLTZ = 5'b00000;
   localparam logic [4:0] RI_BGEZ = 5'b00001;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b11;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      DST_NONE = 2'b00,
      DST_RT   = 2'b01,
      DST_RD   = 2'b10,
      DST_LINK = 2'b11
   } dst_sel_e;

   typedef struct packed {
      logic [5:0] alu_func;
      logic       alu_sel;
      logic       shift_sel;
      logic       ext_sel;
      logic       lui_sel;
      logic       is_branch;
   } ex_ctrl_t;

   typedef struct packed {
      logic       re;
      logic       we;
      logic [1:0] size;
      logic       is_signed;
   } mem_ctrl_t;

   typedef struct packed {
      logic we;
      logic mem_sel;
      logic link_sel;
   } wb_ctrl_t;

   typedef struct packed {
      ex_ctrl_t  ex;
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
   } ctrl_t;

   function automatic logic is_mem_op(input mem_ctrl_t m);
      return m.re | m.we;
   endfunction

endpackage

// File: rtl/pipe_control_decode.sv
// Combinational ID-stage decoder: opcode/func/code to control bundle, destination
// select and source-use flags. Unrecognised encodings decode to an all-zero bubble.
module control_decode
   import pipe_control_pkg::*;
(
   input  logic [5:0] opcode_in,
   input  logic [5:0] func_in,
   input  logic [4:0] code_in,
   output ctrl_t      ctrl_out,
   output dst_sel_e   dst_sel_out,
   output logic       use_rs_out,
   output logic       use_rt_out
);

   always_comb begin
      ctrl_out    = '0;
      dst_sel_out = DST_NONE;
      use_rs_out  = 1'b0;
      use_rt_out  = 1'b0;
      case (opcode_in)
         OP_RTYPE: begin
            case (func_in)
               FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
               FN_SLT, FN_SLTU, FN_SLLV, FN_SRLV, FN_SRAV: begin
                  ctrl_out.ex.alu_func = func_in;
                  ctrl_out.wb.we       = 1'b1;
                  dst_sel_out          = DST_RD;
                  use_rs_out           = 1'b1;
                  use_rt_out           = 1'b1;
               end
               FN_SLL, FN_SRL, FN_SRA: begin
                  ctrl_out.ex.alu_func  = func_in;
                  ctrl_out.ex.shift_sel = 1'b1;
                  ctrl_out.wb.we        = 1'b1;
                  dst_sel_out           = DST_RD;
                  use_rs_out            = 1'b1;
                  use_rt_out            = 1'b1;
               end
               FN_JR: begin
                  ctrl_out.ex.is_branch = 1'b1;
                  use_rs_out            = 1'b1;
               end
               FN_JALR: begin
                  ctrl_out.ex.is_branch = 1'b1;
                  ctrl_out.wb.we        = 1'b1;
                  ctrl_out.wb.link_sel  = 1'b1;
                  dst_sel_out           = DST_LINK;
                  use_rs_out            = 1'b1;
               end
               default: begin
                  ctrl_out = '0;
               end
            endcase
         end
         OP_REGIMM: begin
            case (code_in)
               RI_BLTZ, RI_BGEZ: begin
                  ctrl_out.ex.alu_func  = PF_BR_CMP;
                  ctrl_out.ex.is_branch = 1'b1;
                  use_rs_out            = 1'b1;
               end
               default: begin
                  ctrl_out = '0;
               end
            endcase
         end
         OP_J: begin
            ctrl_out.ex.is_branch = 1'b1;
         end
         OP_JAL: begin
            ctrl_out.ex.is_branch = 1'b1;
            ctrl_out.wb.we        = 1'b1;
            ctrl_out.wb.link_sel  = 1'b1;
            dst_sel_out           = DST_LINK;
         end
         OP_BEQ, OP_BNE: begin
            ctrl_out.ex.alu_func  = PF_BR_EQ;
            ctrl_out.ex.is_branch = 1'b1;
            use_rs_out            = 1'b1;
            use_rt_out            = 1'b1;
         end
         OP_BLEZ, OP_BGTZ: begin
            ctrl_out.ex.alu_func  = PF_BR_CMP;
            ctrl_out.ex.is_branch = 1'b1;
            use_rs_out            = 1'b1;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
            case (opcode_in)
               OP_ADDI:  ctrl_out.ex.alu_func = FN_ADD;
               OP_ADDIU: ctrl_out.ex.alu_func = FN_ADDU;
               OP_SLTI:  ctrl_out.ex.alu_func = FN_SLT;
               OP_SLTIU: ctrl_out.ex.alu_func = FN_SLTU;
               OP_ANDI:  ctrl_out.ex.alu_func = FN_AND;
               OP_ORI:   ctrl_out.ex.alu_func = FN_OR;
               default:  ctrl_out.ex.alu_func = FN_XOR;
            endcase
            // Logical immediates zero-extend; arithmetic and compares sign-extend.
            ctrl_out.ex.ext_sel = (opcode_in == OP_ADDI)  || (opcode_in == OP_ADDIU) ||
                                  (opcode_in == OP_SLTI)  || (opcode_in == OP_SLTIU);
            ctrl_out.ex.alu_sel = 1'b1;
            ctrl_out.wb.we      = 1'b1;
            dst_sel_out         = DST_RT;
            use_rs_out          = 1'b1;
         end
         OP_LUI: begin
            ctrl_out.ex.alu_func = PF_ADDR;
            ctrl_out.ex.alu_sel  = 1'b1;
            ctrl_out.ex.lui_sel  = 1'b1;
            ctrl_out.wb.we       = 1'b1;
            dst_sel_out          = DST_RT;
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            ctrl_out.ex.alu_func   = PF_ADDR;
            ctrl_out.ex.alu_sel    = 1'b1;
            ctrl_out.ex.ext_sel    = 1'b1;
            ctrl_out.mem.re        = 1'b1;
            ctrl_out.mem.size      = (opcode_in == OP_LW) ? SZ_WORD :
                                     ((opcode_in == OP_LH) || (opcode_in == OP_LHU)) ? SZ_HALF : SZ_BYTE;
            ctrl_out.mem.is_signed = (opcode_in == OP_LB) || (opcode_in == OP_LH) || (opcode_in == OP_LW);
            ctrl_out.wb.we         = 1'b1;
            ctrl_out.wb.mem_sel    = 1'b1;
            dst_sel_out            = DST_RT;
            use_rs_out             = 1'b1;
         end
         OP_SB, OP_SH, OP_SW: begin
            ctrl_out.ex.alu_func = PF_ADDR;
            ctrl_out.ex.alu_sel  = 1'b1;
            ctrl_out.ex.ext_sel  = 1'b1;
            ctrl_out.mem.we      = 1'b1;
            ctrl_out.mem.size    = (opcode_in == OP_SW) ? SZ_WORD :
                                   (opcode_in == OP_SH) ? SZ_HALF : SZ_BYTE;
            use_rs_out           = 1'b1;
            use_rt_out           = 1'b1;
         end
         default: begin
            ctrl_out = '0;
         end
      endcase
   end

endmodule

// File: rtl/pipe_control.sv
// Pipelined control path: ID decode, ID/EX, EX/MEM and MEM/WB control registers,
// forwarding selects, load-use stall, branch flush and data-memory wait/timeout.
module pipe_control
   import pipe_control_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int DELAY_SLOT  = 1,
   parameter int MEM_TIMEOUT = 16,
   parameter int LINK_REG    = 31
) (
   input  logic                  clk_in,
   input  logic                  reset_n_in,
   input  logic                  instr_valid_in,
   input  logic [5:0]            opcode_in,
   input  logic [5:0]            func_in,
   input  logic [4:0]            code_in,
   input  logic [REG_ADDR_W-1:0] rs_in,
   input  logic [REG_ADDR_W-1:0] rt_in,
   input  logic [REG_ADDR_W-1:0] rd_in,
   input  logic                  branch_taken_in,
   input  logic                  mem_ready_in,
   output logic                  pc_enable_out,
   output logic                  ifid_enable_out,
   output logic                  ifid_flush_out,
   output logic                  redirect_out,
   output logic [5:0]            ex_alu_func_out,
   output logic                  ex_alu_mux_select_out,
   output logic                  ex_shift_mux_select_out,
   output logic                  ex_extender_mux_select_out,
   output logic                  ex_lui_mux_select_out,
   output logic [1:0]            ex_fwd_a_out,
   output logic [1:0]            ex_fwd_b_out,
   output logic                  mem_re_out,
   output logic                  mem_we_out,
   output logic [1:0]            mem_size_out,
   output logic                  mem_signed_out,
   output logic                  wb_we_out,
   output logic [REG_ADDR_W-1:0] wb_dest_out,
   output logic                  wb_data_mux_select_out,
   output logic                  wb_link_select_out,
   output logic                  mem_error_out
);

   localparam logic [REG_ADDR_W-1:0] LINK_ADDR = REG_ADDR_W'(LINK_REG);
   localparam bit                    SQUASH_SLOT = (DELAY_SLOT == 32'sd0);
   localparam bit                    TIMEOUT_EN  = (MEM_TIMEOUT != 32'sd0);
   localparam int                    CNT_W       = $clog2(MEM_TIMEOUT + 2);
   localparam logic [CNT_W-1:0]      TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

   typedef struct packed {
      logic                  valid;
      ctrl_t                 ctrl;
      logic [REG_ADDR_W-1:0] dest;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
   } idex_t;

   typedef struct packed {
      logic                  valid;
      mem_ctrl_t             mem;
      wb_ctrl_t              wb;
      logic [REG_ADDR_W-1:0] dest;
   } exmem_t;

   typedef struct packed {
      logic                  valid;
      wb_ctrl_t              wb;
      logic [REG_ADDR_W-1:0] dest;
   } memwb_t;

   ctrl_t                 dec_ctrl_s;
   dst_sel_e              dec_dst_sel_s;
   logic                  dec_use_rs_s;
   logic                  dec_use_rt_s;
   ctrl_t                 id_ctrl_s;
   logic [REG_ADDR_W-1:0] id_dest_s;
   logic                  id_use_rs_s;
   logic                  id_use_rt_s;
   logic                  mem_wait_s;
   logic                  take_s;
   logic                  load_use_s;
   logic                  stall_s;
   logic                  timeout_hit_s;

   idex_t                 idex_q,  idex_d;
   exmem_t                exmem_q, exmem_d;
   memwb_t                memwb_q, memwb_d;
   logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
   logic                  mem_err_q, mem_err_d;
   logic                  run_q, run_d;

   control_decode u_decode (
      .opcode_in   (opcode_in),
      .func_in     (func_in),
      .code_in     (code_in),
      .ctrl_out    (dec_ctrl_s),
      .dst_sel_out (dec_dst_sel_s),
      .use_rs_out  (dec_use_rs_s),
      .use_rt_out  (dec_use_rt_s)
   );

   function automatic fwd_sel_e fwd_select(input logic [REG_ADDR_W-1:0] src,
                                           input exmem_t m, input memwb_t w);
      if (m.valid && m.wb.we && !m.mem.re && (m.dest != '0) && (m.dest == src)) begin
         return FWD_MEM;
      end else if (w.valid && w.wb.we && (w.dest == src)) begin
         return FWD_WB;
      end else begin
         return FWD_RF;
      end
   endfunction

   // ID qualification: destination pick, $0 write suppression, invalid-slot bubble.
   always_comb begin
      id_ctrl_s   = dec_ctrl_s;
      id_use_rs_s = dec_use_rs_s & instr_valid_in;
      id_use_rt_s = dec_use_rt_s & instr_valid_in;
      case (dec_dst_sel_s)
         DST_RT:   id_dest_s = rt_in;
         DST_RD:   id_dest_s = rd_in;
         DST_LINK: id_dest_s = LINK_ADDR;
         default:  id_dest_s = '0;
      endcase
      if (!instr_valid_in) begin
         id_ctrl_s = '0;
      end else if (id_dest_s == '0) begin
         id_ctrl_s.wb.we = 1'b0;
      end else begin
         id_ctrl_s = dec_ctrl_s;
      end
   end

   // Hazard resolution; memory wait outranks branch flush, which outranks load-use.
   always_comb begin
      mem_wait_s = exmem_q.valid & is_mem_op(exmem_q.mem) & ~mem_ready_in;
      take_s     = idex_q.valid & idex_q.ctrl.ex.is_branch & branch_taken_in & ~mem_wait_s;
      load_use_s = idex_q.valid & idex_q.ctrl.mem.re & (idex_q.dest != '0) &
                   ((id_use_rs_s & (idex_q.dest == rs_in)) |
                    (id_use_rt_s & (idex_q.dest == rt_in)));
      stall_s    = load_use_s & ~take_s & ~mem_wait_s;
   end

   // Stage advance: freeze on memory wait, bubble MEM/WB meanwhile.
   always_comb begin
      idex_d  = idex_q;
      exmem_d = exmem_q;
      memwb_d = memwb_q;
      run_d   = 1'b1;
      if (mem_wait_s) begin
         memwb_d = '0;
      end else begin
         memwb_d.valid = exmem_q.valid;
         memwb_d.wb    = exmem_q.wb;
         memwb_d.dest  = exmem_q.dest;
         exmem_d.valid = idex_q.valid;
         exmem_d.mem   = idex_q.ctrl.mem;
         exmem_d.wb    = idex_q.ctrl.wb;
         exmem_d.dest  = idex_q.dest;
         if (stall_s || (take_s && SQUASH_SLOT)) begin
            idex_d = '0;
         end else begin
            idex_d.valid = instr_valid_in;
            idex_d.ctrl  = id_ctrl_s;
            idex_d.dest  = id_dest_s;
            idex_d.rs    = rs_in;
            idex_d.rt    = rt_in;
         end
      end
   end

   // Consecutive wait-cycle counter (saturating) and sticky timeout flag.
   always_comb begin
      if (!mem_wait_s) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q == TIMEOUT_CNT) begin
         wait_cnt_d = wait_cnt_q;
      end else begin
         wait_cnt_d = wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      timeout_hit_s = TIMEOUT_EN & mem_wait_s & (wait_cnt_d == TIMEOUT_CNT);
      mem_err_d     = mem_err_q | timeout_hit_s;
   end

   // Control-state registers; reset discards everything in flight.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         idex_q     <= '0;
         exmem_q    <= '0;
         memwb_q    <= '0;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         idex_q     <= idex_d;
         exmem_q    <= exmem_d;
         memwb_q    <= memwb_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
         run_q      <= run_d;
      end
   end

   // Outputs: each stage's strobes gated by its valid bit; run_q holds fetch off in reset.
   always_comb begin
      pc_enable_out              = run_q & ~mem_wait_s & ~stall_s;
      ifid_enable_out            = run_q & ~mem_wait_s & ~stall_s;
      ifid_flush_out             = take_s;
      redirect_out               = take_s;
      ex_alu_func_out            = idex_q.valid ? idex_q.ctrl.ex.alu_func : 6'b000000;
      ex_alu_mux_select_out      = idex_q.valid & idex_q.ctrl.ex.alu_sel;
      ex_shift_mux_select_out    = idex_q.valid & idex_q.ctrl.ex.shift_sel;
      ex_extender_mux_select_out = idex_q.valid & idex_q.ctrl.ex.ext_sel;
      ex_lui_mux_select_out      = idex_q.valid & idex_q.ctrl.ex.lui_sel;
      ex_fwd_a_out               = idex_q.valid ? fwd_select(idex_q.rs, exmem_q, memwb_q) : FWD_RF;
      ex_fwd_b_out               = idex_q.valid ? fwd_select(idex_q.rt, exmem_q, memwb_q) : FWD_RF;
      mem_re_out                 = exmem_q.valid & exmem_q.mem.re;
      mem_we_out                 = exmem_q.valid & exmem_q.mem.we;
      mem_size_out               = (exmem_q.valid && is_mem_op(exmem_q.mem)) ? exmem_q.mem.size : 2'b00;
      mem_signed_out             = exmem_q.valid & exmem_q.mem.re & exmem_q.mem.is_signed;
      wb_we_out                  = memwb_q.valid & memwb_q.wb.we;
      wb_dest_out                = memwb_q.valid ? memwb_q.dest : '0;
      wb_data_mux_select_out     = memwb_q.valid & memwb_q.wb.mem_sel;
      wb_link_select_out         = memwb_q.valid & memwb_q.wb.link_sel;
      mem_error_out              = mem_err_q | timeout_hit_s;
   end

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench: two instances (delay slot on / off) share stimulus; expectations hand-computed.
module tb_pipe_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ivalid;
   logic [5:0] opcode, func;
   logic [4:0] code, rs, rt, rd;
   logic       taken, ready;

   logic       a_pc, a_ifen, a_flush, a_redir, a_amux, a_smux, a_emux, a_lmux;
   logic       a_re, a_we, a_sgn, a_wbwe, a_dmux, a_link, a_err;
   logic [5:0] a_func;
   logic [1:0] a_fa, a_fb, a_size;
   logic [4:0] a_dest;
   logic       b_pc, b_ifen, b_flush, b_redir, b_amux, b_smux, b_emux, b_lmux;
   logic       b_re, b_we, b_sgn, b_wbwe, b_dmux, b_link, b_err;
   logic [5:0] b_func;
   logic [1:0] b_fa, b_fb, b_size;
   logic [4:0] b_dest;
   logic [31:0] a_all, b_all;

   int total = 0;
   int bad   = 0;
   int wb_count;

   always #5 clk = ~clk;

   assign a_all = {a_pc, a_ifen, a_flush, a_redir, a_func, a_amux, a_smux, a_emux, a_lmux,
                   a_fa, a_fb, a_re, a_we, a_size, a_sgn, a_wbwe, a_dest, a_dmux, a_link, a_err};
   assign b_all = {b_pc, b_ifen, b_flush, b_redir, b_func, b_amux, b_smux, b_emux, b_lmux,
                   b_fa, b_fb, b_re, b_we, b_size, b_sgn, b_wbwe, b_dest, b_dmux, b_link, b_err};

   pipe_control #(.REG_ADDR_W(5), .DELAY_SLOT(1), .MEM_TIMEOUT(4), .LINK_REG(31)) dut_a (
      .clk_in(clk), .reset_n_in(rst_n), .instr_valid_in(ivalid), .opcode_in(opcode),
      .func_in(func), .code_in(code), .rs_in(rs), .rt_in(rt), .rd_in(rd),
      .branch_taken_in(taken), .mem_ready_in(ready),
      .pc_enable_out(a_pc), .ifid_enable_out(a_ifen), .ifid_flush_out(a_flush),
      .redirect_out(a_redir), .ex_alu_func_out(a_func), .ex_alu_mux_select_out(a_amux),
      .ex_shift_mux_select_out(a_smux), .ex_extender_mux_select_out(a_emux),
      .ex_lui_mux_select_out(a_lmux), .ex_fwd_a_out(a_fa), .ex_fwd_b_out(a_fb),
      .mem_re_out(a_re), .mem_we_out(a_we), .mem_size_out(a_size), .mem_signed_out(a_sgn),
      .wb_we_out(a_wbwe), .wb_dest_out(a_dest), .wb_data_mux_select_out(a_dmux),
      .wb_link_select_out(a_link), .mem_error_out(a_err));

   pipe_control #(.REG_ADDR_W(5), .DELAY_SLOT(0), .MEM_TIMEOUT(4), .LINK_REG(31)) dut_b (
      .clk_in(clk), .reset_n_in(rst_n), .instr_valid_in(ivalid), .opcode_in(opcode),
      .func_in(func), .code_in(code), .rs_in(rs), .rt_in(rt), .rd_in(rd),
      .branch_taken_in(taken), .mem_ready_in(ready),
      .pc_enable_out(b_pc), .ifid_enable_out(b_ifen), .ifid_flush_out(b_flush),
      .redirect_out(b_redir), .ex_alu_func_out(b_func), .ex_alu_mux_select_out(b_amux),
      .ex_shift_mux_select_out(b_smux), .ex_extender_mux_select_out(b_emux),
      .ex_lui_mux_select_out(b_lmux), .ex_fwd_a_out(b_fa), .ex_fwd_b_out(b_fb),
      .mem_re_out(b_re), .mem_we_out(b_we), .mem_size_out(b_size), .mem_signed_out(b_sgn),
      .wb_we_out(b_wbwe), .wb_dest_out(b_dest), .wb_data_mux_select_out(b_dmux),
      .wb_link_select_out(b_link), .mem_error_out(b_err));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
      ivalid = 1'b1;
      opcode = op;
      func   = fn;
      rs     = s;
      rt     = t;
      code   = t;
      rd     = d;
   endtask

   task automatic bubble();
      ivalid = 1'b0;
      opcode = 6'b000000;
      func   = 6'b000000;
      rs     = 5'd0;
      rt     = 5'd0;
      code   = 5'd0;
      rd     = 5'd0;
   endtask

   initial begin
      logic [3:0] exp_we, exp_pc;
      rst_n = 1'b0;
      taken = 1'b0;
      ready = 1'b1;
      bubble();

      // Reset: every output low, including fetch enable.
      smp();
      chk("reset_all_a", a_all, 32'h0);
      chk("reset_all_b", b_all, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      smp();
      chk("release_cycle_pc", {31'd0, a_pc}, 32'd0);
      tick();

      // add $3,$1,$2 ; add $4,$3,$3
      drive(6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3);
      smp();
      chk("first_fetch_pc", {31'd0, a_pc}, 32'd1);
      chk("first_fetch_ifid", {31'd0, a_ifen}, 32'd1);
      tick();
      drive(6'b000000, 6'b100000, 5'd3, 5'd3, 5'd4);
      smp();
      chk("add_ex_func", {26'd0, a_func}, 32'h20);
      tick();
      bubble();
      smp();
      chk("add_fwd_a", {30'd0, a_fa}, 32'd1);
      chk("add_fwd_b", {30'd0, a_fb}, 32'd1);
      tick();
      smp();
      chk("add1_wb", {26'd0, a_wbwe, a_dest}, {26'd0, 1'b1, 5'd3});
      tick();
      smp();
      chk("add2_wb", {26'd0, a_wbwe, a_dest}, {26'd0, 1'b1, 5'd4});
      tick();

      // lw $5,0($1) ; add $6,$5,$0  -> one stall cycle, then WB forward
      drive(6'b100011, 6'b000000, 5'd1, 5'd5, 5'd0);
      smp();
      tick();
      drive(6'b000000, 6'b100000, 5'd5, 5'd0, 5'd6);
      smp();
      chk("lu_stall_pc", {31'd0, a_pc}, 32'd0);
      chk("lu_stall_ifid", {31'd0, a_ifen}, 32'd0);
      tick();
      smp();
      chk("lu_release_pc", {31'd0, a_pc}, 32'd1);
      chk("lw_mem_re_size", {29'd0, a_re, a_size}, {29'd0, 1'b1, 2'b11});
      tick();
      bubble();
      smp();
      chk("lu_fwd_a", {30'd0, a_fa}, 32'd2);
      chk("lu_fwd_b", {30'd0, a_fb}, 32'd0);
      chk("lw_wb", {25'd0, a_wbwe, a_dmux, a_dest}, {25'd0, 1'b1, 1'b1, 5'd5});
      tick();
      tick();

      // beq $1,$2 taken ; delay slot add $7,$1,$2
      drive(6'b000100, 6'b000000, 5'd1, 5'd2, 5'd0);
      smp();
      tick();
      drive(6'b000000, 6'b100000, 5'd1, 5'd2, 5'd7);
      taken = 1'b1;
      smp();
      chk("br_redirect_flush_a", {30'd0, a_redir, a_flush}, 32'd3);
      chk("br_redirect_flush_b", {30'd0, b_redir, b_flush}, 32'd3);
      tick();
      bubble();
      smp();
      chk("br_one_cycle_a", {30'd0, a_redir, a_flush}, 32'd0);
      tick();
      taken = 1'b0;
      smp();
      tick();
      smp();
      chk("slot_wb_a", {26'd0, a_wbwe, a_dest}, {26'd0, 1'b1, 5'd7});
      chk("slot_wb_b", {31'd0, b_wbwe}, 32'd0);
      tick();

      // add $8 ; sw $2,0($1) with three not-ready cycles
      drive(6'b000000, 6'b100000, 5'd1, 5'd2, 5'd8);
      smp();
      tick();
      drive(6'b101011, 6'b000000, 5'd1, 5'd2, 5'd0);
      smp();
      tick();
      bubble();
      smp();
      chk("sw_ex_alu_mux", {31'd0, a_amux}, 32'd1);
      tick();
      ready    = 1'b0;
      wb_count = 0;
      exp_we   = 4'b1111;
      exp_pc   = 4'b1000;
      for (int i = 0; i < 5; i++) begin
         if (i == 3) ready = 1'b1;
         smp();
         if (i < 4) begin
            chk($sformatf("wait_mem_we_%0d", i), {31'd0, a_we}, {31'd0, exp_we[i]});
            chk($sformatf("wait_pc_%0d", i), {31'd0, a_pc}, {31'd0, exp_pc[i]});
         end else begin
            chk("wait_done_mem_we", {31'd0, a_we}, 32'd0);
         end
         if (a_wbwe) wb_count++;
         tick();
      end
      chk("wait_single_wb", wb_count, 32'd1);
      chk("wait_no_error", {31'd0, a_err}, 32'd0);

      // lw $9 with six not-ready cycles: error rises on the 4th, then reset mid-wait
      drive(6'b100011, 6'b000000, 5'd1, 5'd9, 5'd0);
      smp();
      tick();
      bubble();
      smp();
      tick();
      ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         smp();
         chk($sformatf("timeout_err_%0d", i), {31'd0, a_err}, {31'd0, (i >= 3)});
         if (i < 5) tick();
      end
      #2 rst_n = 1'b0;
      #1;
      chk("reset_mid_wait_a", a_all, 32'h0);
      chk("reset_mid_wait_b", b_all, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      ready = 1'b1;
      tick();
      smp();
      chk("after_reset", {29'd0, a_pc, a_err, a_re}, {29'd0, 1'b1, 1'b0, 1'b0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
